// File: rtl/player_motion_controller.sv
// ============================================================================
// player_motion_controller: two-axis button-driven player position with
// arena clamping, blocking-ball contact and a bludger stun countdown.
// Revision: 1.0
// ============================================================================
`default_nettype none

module player_motion_controller #(
    parameter int PLAYER_RADIUS    = 25,
    parameter int BLOCK_RADIUS     = 25,
    parameter int BLOCK_MARGIN     = 2,
    parameter int INITIAL_X        = 320,
    parameter int INITIAL_Y        = 200,
    parameter int LEFT_BOUNDARY    = 0,
    parameter int RIGHT_BOUNDARY   = 639,
    parameter int TOP_BOUNDARY     = 0,
    parameter int BOT_BOUNDARY     = 479,
    parameter int STEP_PERIOD      = 200000,
    parameter int TICKS_PER_SECOND = 50000000,
    parameter int STUN_SECONDS     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bludged,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [9:0] block_x,
    input  logic [9:0] block_y,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [3:0] stun_time,
    output logic       stun_done,
    output logic       moving
);

    localparam int STEP_W = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
    localparam int SEC_W  = (TICKS_PER_SECOND > 2) ? $clog2(TICKS_PER_SECOND) : 1;

    localparam logic [1:0] c_FREE    = 2'd0;
    localparam logic [1:0] c_STUNNED = 2'd1;
    localparam logic [1:0] c_EXPIRED = 2'd2;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_NEG  = 2'b01;
    localparam logic [1:0] c_POS  = 2'b10;

    localparam logic [9:0]        c_X_MIN    = 10'(LEFT_BOUNDARY + PLAYER_RADIUS);
    localparam logic [9:0]        c_X_MAX    = 10'(RIGHT_BOUNDARY - PLAYER_RADIUS);
    localparam logic [9:0]        c_Y_MIN    = 10'(TOP_BOUNDARY + PLAYER_RADIUS);
    localparam logic [9:0]        c_Y_MAX    = 10'(BOT_BOUNDARY - PLAYER_RADIUS);
    localparam int                c_CDIST    = PLAYER_RADIUS + BLOCK_RADIUS + BLOCK_MARGIN;
    localparam logic [21:0]       c_CONTACT2 = 22'(c_CDIST * c_CDIST);
    localparam logic [3:0]        c_STUN     = 4'(STUN_SECONDS);
    localparam logic [STEP_W-1:0] c_STEP_TC  = STEP_W'(STEP_PERIOD - 1);
    localparam logic [SEC_W-1:0]  c_SEC_TC   = SEC_W'(TICKS_PER_SECOND - 1);

    logic [1:0]        state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [3:0]        stun_q, stun_d;
    logic              done_q, done_d;
    logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [STEP_W-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic [1:0]        dir_x_q, dir_y_q;
    logic              moving_q;

    logic              w_sec_tc;
    logic              w_frozen;
    logic [1:0]        w_dir_x, w_dir_y;
    logic [STEP_W-1:0] w_eff_x, w_eff_y;
    logic              w_tc_x, w_tc_y, w_ok_x, w_ok_y, w_step_x, w_step_y;
    logic signed [10:0] w_dx, w_dy;
    logic [10:0]       w_adx, w_ady;
    logic [21:0]       w_d2;
    logic              w_contact;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_FREE;
            sec_q    <= '0;
            stun_q   <= c_STUN;
            done_q   <= 1'b0;
            pos_x_q  <= 10'(INITIAL_X);
            pos_y_q  <= 10'(INITIAL_Y);
            cnt_x_q  <= '0;
            cnt_y_q  <= '0;
            dir_x_q  <= c_IDLE;
            dir_y_q  <= c_IDLE;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec_d;
            stun_q   <= stun_d;
            done_q   <= done_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            cnt_x_q  <= cnt_x_d;
            cnt_y_q  <= cnt_y_d;
            dir_x_q  <= w_dir_x;
            dir_y_q  <= w_dir_y;
            moving_q <= w_step_x | w_step_y;
        end
    end

    assign w_sec_tc = (sec_q == c_SEC_TC);

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_FREE:    if (bludged) state_d = c_STUNNED;
            c_STUNNED: begin
                if (!bludged)                        state_d = c_FREE;
                else if (w_sec_tc && stun_q == 4'd1) state_d = c_EXPIRED;
            end
            c_EXPIRED: if (!bludged) state_d = c_FREE;
            default:   state_d = c_FREE;
        endcase
    end

    // ------------------------------------------------------ stun bookkeeping
    always_comb begin
        sec_d  = sec_q;
        stun_d = stun_q;
        done_d = done_q;
        case (state_q)
            c_STUNNED: begin
                if (!bludged) begin
                    sec_d  = '0;
                    stun_d = c_STUN;
                    done_d = 1'b0;
                end else if (w_sec_tc) begin
                    sec_d  = '0;
                    stun_d = stun_q - 4'd1;
                    done_d = (stun_q == 4'd1);
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
            c_EXPIRED: begin
                sec_d  = '0;
                stun_d = bludged ? stun_q : c_STUN;
                done_d = bludged;
            end
            default: begin
                sec_d  = '0;
                stun_d = c_STUN;
                done_d = 1'b0;
            end
        endcase
    end

    assign w_frozen = bludged || (state_q != c_FREE);

    // Opposing buttons cancel, leaving the axis idle.
    assign w_dir_x = (!btn_left && btn_right)  ? c_NEG :
                     (!btn_right && btn_left)  ? c_POS : c_IDLE;
    assign w_dir_y = (!btn_up && btn_down)     ? c_NEG :
                     (!btn_down && btn_up)     ? c_POS : c_IDLE;

    // ------------------------------------------------------- contact check
    assign w_dx      = signed'({1'b0, pos_x_q}) - signed'({1'b0, block_x});
    assign w_dy      = signed'({1'b0, pos_y_q}) - signed'({1'b0, block_y});
    assign w_adx     = w_dx[10] ? 11'(-w_dx) : 11'(w_dx);
    assign w_ady     = w_dy[10] ? 11'(-w_dy) : 11'(w_dy);
    assign w_d2      = (22'(w_adx) * 22'(w_adx)) + (22'(w_ady) * 22'(w_ady));
    assign w_contact = (w_d2 < c_CONTACT2);

    // ------------------------------------------------------- step timing
    // A direction change restarts the period as if it were a fresh press.
    always_comb begin
        w_eff_x = (w_dir_x != dir_x_q) ? '0 : cnt_x_q;
        w_eff_y = (w_dir_y != dir_y_q) ? '0 : cnt_y_q;
        w_tc_x  = !w_frozen && (w_dir_x != c_IDLE) && (w_eff_x == c_STEP_TC);
        w_tc_y  = !w_frozen && (w_dir_y != c_IDLE) && (w_eff_y == c_STEP_TC);
        cnt_x_d = (w_frozen || w_dir_x == c_IDLE || w_tc_x) ? '0 : w_eff_x + STEP_W'(1);
        cnt_y_d = (w_frozen || w_dir_y == c_IDLE || w_tc_y) ? '0 : w_eff_y + STEP_W'(1);

        if (w_dir_x == c_NEG)
            w_ok_x = (pos_x_q > c_X_MIN) && !(w_contact && pos_x_q >= block_x);
        else
            w_ok_x = (pos_x_q < c_X_MAX) && !(w_contact && pos_x_q <= block_x);
        if (w_dir_y == c_NEG)
            w_ok_y = (pos_y_q > c_Y_MIN) && !(w_contact && pos_y_q >= block_y);
        else
            w_ok_y = (pos_y_q < c_Y_MAX) && !(w_contact && pos_y_q <= block_y);

        w_step_x = w_tc_x && w_ok_x;
        w_step_y = w_tc_y && w_ok_y;

        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (w_step_x) pos_x_d = (w_dir_x == c_NEG) ? pos_x_q - 10'd1 : pos_x_q + 10'd1;
        if (w_step_y) pos_y_d = (w_dir_y == c_NEG) ? pos_y_q - 10'd1 : pos_y_q + 10'd1;
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign stun_time = stun_q;
    assign stun_done = done_q;
    assign moving    = moving_q;

endmodule

`default_nettype wire

// File: tb/tb_player_motion_controller.sv
// ============================================================================
// tb_player_motion_controller: directed self-checking bench for the player
// motion controller (short step period and stun timing).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_player_motion_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       bludged;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [9:0] block_x, block_y;
    logic [9:0] pos_x, pos_y;
    logic [3:0] stun_time;
    logic       stun_done;
    logic       moving;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    player_motion_controller #(
        .STEP_PERIOD      (4),
        .TICKS_PER_SECOND (8),
        .STUN_SECONDS     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bludged   (bludged),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .block_x   (block_x),
        .block_y   (block_y),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .stun_time (stun_time),
        .stun_done (stun_done),
        .moving    (moving)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int n;
        rst = 1'b1; bludged = 1'b0;
        btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
        block_x = 10'd620; block_y = 10'd460;
        tick(); tick();
        chk("rst_pos_x", pos_x, 320);
        chk("rst_pos_y", pos_y, 200);
        chk("rst_stun_time", stun_time, 3);
        chk("rst_stun_done", stun_done, 0);
        chk("rst_moving", moving, 0);
        rst = 1'b0;

        // Hold right: steps land on every 4th edge.
        btn_right = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("right_moving", moving, (k % 4 == 0) ? 1 : 0);
            chk("right_pos_x", pos_x, 320 + k / 4);
        end
        chk("right_pos_y", pos_y, 200);
        btn_right = 1'b1;
        tick();
        chk("right_release_moving", moving, 0);

        // Up+down cancel while left runs independently.
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
        repeat (8) tick();
        chk("diag_pos_y", pos_y, 200);
        chk("diag_pos_x", pos_x, 321);
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (4) tick();
        chk("left_pos_x", pos_x, 320);
        btn_left = 1'b1;
        tick();

        // Ball below the player: down blocked, up free.
        block_x = 10'd320; block_y = 10'd250;
        btn_down = 1'b0;
        pulses = 0;
        repeat (12) begin tick(); pulses += int'(moving); end
        chk("blk_down_pulses", pulses, 0);
        chk("blk_down_pos_y", pos_y, 200);
        btn_down = 1'b1;
        tick();
        btn_up = 1'b0;
        repeat (4) tick();
        chk("blk_up_pos_y", pos_y, 199);
        btn_up = 1'b1;
        tick();

        // Ball to the right: right blocked, left free.
        block_x = 10'd370; block_y = 10'd199;
        btn_right = 1'b0;
        pulses = 0;
        repeat (8) begin tick(); pulses += int'(moving); end
        chk("blk_right_pulses", pulses, 0);
        chk("blk_right_pos_x", pos_x, 320);
        btn_right = 1'b1;
        tick();
        btn_left = 1'b0;
        repeat (4) tick();
        chk("blk_left_pos_x", pos_x, 319);
        btn_left = 1'b1;
        tick();
        block_x = 10'd620; block_y = 10'd460;

        // Walk up to the top clamp.
        btn_up = 1'b0;
        n = 0;
        while (pos_y != 10'd26 && n < 1000) begin tick(); n++; end
        chk("top_reach_26", pos_y, 26);
        pulses = 0;
        repeat (40) begin tick(); pulses += int'(moving); end
        chk("top_last_pulses", pulses, 1);
        chk("top_clamp_pos_y", pos_y, 25);
        btn_up = 1'b1;
        tick();

        // Stun while holding right.
        bludged = 1'b1; btn_right = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("stun_pos_x", pos_x, 319);
            chk("stun_moving", moving, 0);
            chk("stun_time", stun_time, (k < 9) ? 3 : (k < 17) ? 2 : (k < 25) ? 1 : 0);
            chk("stun_done", stun_done, (k >= 25) ? 1 : 0);
        end
        bludged = 1'b0;
        tick();
        chk("unstun_time", stun_time, 3);
        chk("unstun_done", stun_done, 0);
        chk("unstun_pos_x", pos_x, 319);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("resume_wait_pos_x", pos_x, 319);
        end
        tick();
        chk("resume_pos_x", pos_x, 320);
        chk("resume_moving", moving, 1);
        btn_right = 1'b1;
        tick();

        // Reset in the middle of a stun.
        bludged = 1'b1;
        repeat (17) tick();
        chk("midstun_time", stun_time, 1);
        rst = 1'b1; bludged = 1'b0;
        tick();
        chk("rst2_pos_x", pos_x, 320);
        chk("rst2_pos_y", pos_y, 200);
        chk("rst2_stun_time", stun_time, 3);
        chk("rst2_stun_done", stun_done, 0);
        chk("rst2_moving", moving, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_stun_time", stun_time, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
